// File: rtl/cordic_share_ctrl.sv
// cordic_share_ctrl
//   Shares one iterative CORDIC cosine core between two requesters using a
//   round-robin arbiter. An operation loads the core (core_aclr), enables it
//   for ITERS cycles (core_clk_en), then captures core_result. The result is
//   returned to the owning requester with a one-cycle done pulse.
// Ports
//   clock, aclr                   clock, synchronous active-high reset
//   start0/1, dataa0/1            request pulse and 32-bit FP operand
//   busy0/1                       request pending or in flight
//   done0/1, result0/1            one-cycle completion pulse, held result
//   core_aclr, core_clk_en        core load strobe and iteration enable
//   core_dataa, core_result       operand to / result from the core
module cordic_share_ctrl #(
  parameter int unsigned ITERS = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic        clock,
  input  logic        aclr,
  input  logic        start0,
  input  logic [31:0] dataa0,
  output logic        busy0,
  output logic        done0,
  output logic [31:0] result0,
  input  logic        start1,
  input  logic [31:0] dataa1,
  output logic        busy1,
  output logic        done1,
  output logic [31:0] result1,
  output logic        core_aclr,
  output logic        core_clk_en,
  output logic [31:0] core_dataa,
  input  logic [31:0] core_result
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  state_t      state, state_nxt;
  logic        pending0, pending1;
  logic        grant, last;
  logic [CNT_W-1:0] cnt;
  logic [31:0] op0, op1;
  logic        done0_q, done1_q;
  logic [31:0] res0_q, res1_q;

  always_ff @(posedge clock) begin
    if (aclr) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pending0 || pending1) state_nxt = LOAD;
      LOAD: state_nxt = RUN;
      RUN:  if (cnt == CNT_LAST) state_nxt = CAPT;
      CAPT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (aclr) begin
      pending0 <= 1'b0;
      pending1 <= 1'b0;
      op0      <= '0;
      op1      <= '0;
      grant    <= 1'b0;
      last     <= 1'b1;
      cnt      <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      res0_q   <= '0;
      res1_q   <= '0;
    end else begin
      done0_q <= (state == CAPT) && !grant;
      done1_q <= (state == CAPT) && grant;

      // The CAPT clear takes priority, so a start in that cycle is dropped.
      if ((state == CAPT) && !grant) pending0 <= 1'b0;
      else if (start0 && !pending0) begin
        pending0 <= 1'b1;
        op0      <= dataa0;
      end

      if ((state == CAPT) && grant) pending1 <= 1'b0;
      else if (start1 && !pending1) begin
        pending1 <= 1'b1;
        op1      <= dataa1;
      end

      case (state)
        IDLE: if (pending0 || pending1) grant <= (pending0 && pending1) ? ~last : pending1;
        LOAD: cnt <= '0;
        RUN:  cnt <= cnt + 1'b1;
        CAPT: begin
          if (grant) res1_q <= core_result;
          else       res0_q <= core_result;
          last <= grant;
        end
        default: ;
      endcase
    end
  end

  // Reset is synchronous, so the registered state can still read LOAD/RUN
  // during an aclr cycle; gating keeps the outputs quiet for that cycle.
  always_comb begin
    core_aclr   = aclr | (state == LOAD);
    core_clk_en = ~aclr & (state == RUN);
    core_dataa  = '0;
    if (!aclr && (state == LOAD || state == RUN))
      core_dataa = grant ? op1 : op0;
    busy0   = ~aclr & pending0;
    busy1   = ~aclr & pending1;
    done0   = ~aclr & done0_q;
    done1   = ~aclr & done1_q;
    result0 = aclr ? '0 : res0_q;
    result1 = aclr ? '0 : res1_q;
  end

endmodule

// File: tb/tb_cordic_share_ctrl.sv
module tb_cordic_share_ctrl;

  logic        clock = 1'b0;
  logic        aclr;
  logic        start0, start1;
  logic [31:0] dataa0, dataa1;
  logic        busy0, busy1, done0, done1;
  logic [31:0] result0, result1;
  logic        core_aclr, core_clk_en;
  logic [31:0] core_dataa, core_result;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clock = ~clock;

  cordic_share_ctrl #(.ITERS(16), .CNT_W(5)) dut (
    .clock(clock), .aclr(aclr),
    .start0(start0), .dataa0(dataa0), .busy0(busy0), .done0(done0), .result0(result0),
    .start1(start1), .dataa1(dataa1), .busy1(busy1), .done1(done1), .result1(result1),
    .core_aclr(core_aclr), .core_clk_en(core_clk_en),
    .core_dataa(core_dataa), .core_result(core_result)
  );

  // Stand-in core: a scrambling step per enabled cycle, so a wrong number
  // of enables or a wrong operand produces a different result.
  logic [31:0] core_q;
  always @(posedge clock) begin
    if (core_aclr)        core_q <= core_dataa;
    else if (core_clk_en) core_q <= {core_q[30:0], core_q[31]} ^ 32'h9E3779B9;
  end
  assign core_result = core_q;

  function automatic logic [31:0] fmodel(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    for (int i = 0; i < 16; i++) y = {y[30:0], y[31]} ^ 32'h9E3779B9;
    return y;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Continuous checks: enable count per operation, exclusive done, result stability.
  int unsigned en_cnt = 0;
  logic [31:0] prev0 = '0, prev1 = '0;
  always begin
    @(negedge clock);
    #1;
    if (core_aclr)        en_cnt = 0;
    else if (core_clk_en) en_cnt++;
    if (!aclr) begin
      if (done0 || done1) check("enables_per_op", en_cnt, 16);
      check("done_exclusive", {31'b0, done0 & done1}, 0);
      if (!done0) check("result0_stable", result0, prev0);
      if (!done1) check("result1_stable", result1, prev1);
    end
    prev0 = result0;
    prev1 = result1;
  end

  typedef struct {
    logic        s0;
    logic [31:0] d0;
    logic        s1;
    logic [31:0] d1;
    int unsigned at0;  // done0 cycle offset from start, 0 = none
    int unsigned at1;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v);
    int unsigned t0, t1, n0, n1;
    logic [31:0] r0, r1;
    logic drop0, drop1;
    t0 = 0; t1 = 0; n0 = 0; n1 = 0; r0 = '0; r1 = '0; drop0 = 0; drop1 = 0;
    @(negedge clock);
    start0 = v.s0; dataa0 = v.d0; start1 = v.s1; dataa1 = v.d1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clock);
      if (k == 1) begin
        start0 = 0; start1 = 0;
        check("busy0_after_start", {31'b0, busy0}, {31'b0, v.s0});
        check("busy1_after_start", {31'b0, busy1}, {31'b0, v.s1});
      end
      if (v.at0 != 0 && k < v.at0 && !busy0) drop0 = 1;
      if (v.at1 != 0 && k < v.at1 && !busy1) drop1 = 1;
      if (done0) begin t0 = k; r0 = result0; n0++; end
      if (done1) begin t1 = k; r1 = result1; n1++; end
    end
    check("done0_cycle", t0, v.at0);
    check("done1_cycle", t1, v.at1);
    check("done0_count", n0, (v.at0 != 0) ? 1 : 0);
    check("done1_count", n1, (v.at1 != 0) ? 1 : 0);
    if (v.at0 != 0) check("result0", r0, fmodel(v.d0));
    if (v.at1 != 0) check("result1", r1, fmodel(v.d1));
    check("busy_held", {30'b0, drop1, drop0}, 0);
  endtask

  initial begin
    int unsigned ndone, nexp;
    int unsigned t, cnt0;
    logic [31:0] r;
    logic [31:0] cur0, cur1;
    logic        g;

    // Expected orders follow round-robin history: last starts at 1.
    vecs[0] = '{1'b1, 32'h3F000000, 1'b0, 32'h0,        20, 0};
    vecs[1] = '{1'b0, 32'h0,        1'b1, 32'h40000000, 0,  20};
    vecs[2] = '{1'b1, 32'h3F800000, 1'b1, 32'h40490FDB, 20, 39};
    vecs[3] = '{1'b1, 32'h3E800000, 1'b0, 32'h0,        20, 0};
    vecs[4] = '{1'b1, 32'hBF000000, 1'b1, 32'h3DCCCCCD, 39, 20};

    aclr = 1; start0 = 0; start1 = 0; dataa0 = '0; dataa1 = '0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_core_aclr", {31'b0, core_aclr}, 1);
    check("rst_outputs", {26'b0, busy0, busy1, done0, done1, core_clk_en, 1'b0}, 0);
    check("rst_core_dataa", core_dataa, 0);
    check("rst_result0", result0, 0);
    check("rst_result1", result1, 0);
    @(negedge clock);
    aclr = 0;
    @(negedge clock);
    check("idle_core_aclr", {31'b0, core_aclr}, 0);
    check("idle_busy", {30'b0, busy0, busy1}, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Fairness: both requesters reissue as soon as their done arrives.
    // last is 0 here, so requester 1 wins the opening tie.
    cur0 = 32'h3F100000; cur1 = 32'h3F200000;
    @(negedge clock);
    start0 = 1; dataa0 = cur0; start1 = 1; dataa1 = cur1;
    ndone = 0;
    for (int k = 0; k < 400 && ndone < 8; k++) begin
      @(negedge clock);
      start0 = 0; start1 = 0;
      if (done0 || done1) begin
        g = done1;
        check("fair_grant", {31'b0, g}, (ndone % 2 == 0) ? 1 : 0);
        check("fair_result", g ? result1 : result0, fmodel(g ? cur1 : cur0));
        ndone++;
        if (ndone < 8) begin
          if (g) begin cur1 = cur1 + 32'h10; start1 = 1; dataa1 = cur1; end
          else   begin cur0 = cur0 + 32'h10; start0 = 1; dataa0 = cur0; end
        end
      end
    end
    check("fair_total", ndone, 8);
    repeat (45) @(negedge clock);

    // Duplicate start mid-RUN is ignored.
    @(negedge clock);
    start0 = 1; dataa0 = 32'h3F000000;
    t = 0; cnt0 = 0; r = '0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clock);
      start0 = 0;
      if (k == 8) begin start0 = 1; dataa0 = 32'h3F800000; end
      if (done0) begin t = k; r = result0; cnt0++; end
    end
    check("dup_done_cycle", t, 20);
    check("dup_done_count", cnt0, 1);
    check("dup_result", r, fmodel(32'h3F000000));

    // Reset during RUN cycle 7 abandons the op.
    @(negedge clock);
    start0 = 1; dataa0 = 32'h3E000000;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      start0 = 0;
    end
    aclr = 1;
    #1;
    check("midrst_core_aclr", {31'b0, core_aclr}, 1);
    check("midrst_clk_en", {31'b0, core_clk_en}, 0);
    check("midrst_busy", {30'b0, busy0, busy1}, 0);
    @(negedge clock);
    aclr = 0;
    nexp = 0;
    check("midrst_no_done", {30'b0, done0, done1}, 0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (done0 || done1 || busy0 || busy1) nexp++;
    end
    check("midrst_quiet", nexp, 0);
    @(negedge clock);
    start0 = 1; dataa0 = 32'h3F000000;
    t = 0; r = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      start0 = 0;
      if (done0 && t == 0) begin t = k; r = result0; end
    end
    check("post_rst_done_cycle", t, 20);
    check("post_rst_result", r, fmodel(32'h3F000000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
